// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the SRAM responder: transfer kinds, sizes,
// response codes, slave FSM states and byte-lane decode.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BYTE = 3'd0,
    HALF = 3'd1,
    WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_ERR1,
    S_ERR2
  } slave_state_e;

  // Little-endian byte enables for a transfer of the given size and low address bits.
  function automatic logic [3:0] lane_enable(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] lanes;
    case (size)
      BYTE:    lanes = 4'b0001 << addr;
      HALF:    lanes = addr[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Word-organised backing store with per-byte write enables and a
// combinational read port sharing the same word address.
module ahb_slave_mem #(
  parameter int WORDS = 256,
  parameter int IW    = 8
) (
  input  logic          hclk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge hclk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite memory-backed responder: address-phase capture, error decode,
// programmable wait states and the two-cycle ERROR response.
module ahb_lite_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata
);

  localparam int WORDS = MEM_BYTES / 4;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0]   WS_LOAD   = CW'(WAIT_STATES);
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

  slave_state_e      state, next_state;
  logic [CW-1:0]     wait_cnt;
  logic [IW-1:0]     word_q;
  logic [3:0]        lanes_q;
  logic              write_q;
  logic              accept, addr_err, done, can_accept, load, mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_bits;

  // Burst type is irrelevant because every beat is decoded on its own.
  assign unused_bits = ^{hburst, htrans[0]};

  assign accept   = hsel && hready && htrans[1];
  assign done     = (wait_cnt == '0);
  assign addr_err = ({1'b0, haddr} >= MEM_LIMIT)
                 || (hsize > 3'(WORD))
                 || ((hsize == 3'(HALF)) && haddr[0])
                 || ((hsize == 3'(WORD)) && (haddr[1:0] != 2'b00));

  always_comb begin
    next_state = state;
    hreadyout  = 1'b1;
    hresp      = HRESP_OKAY;
    mem_we     = 1'b0;
    can_accept = 1'b0;
    case (state)
      S_IDLE: can_accept = 1'b1;
      S_DATA: begin
        hreadyout  = done;
        can_accept = done;
        mem_we     = write_q && done;
        if (done) next_state = S_IDLE;
      end
      S_ERR1: begin
        hreadyout  = 1'b0;
        hresp      = HRESP_ERROR;
        next_state = S_ERR2;
      end
      S_ERR2: begin
        hresp      = HRESP_ERROR;
        can_accept = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    load = can_accept && accept;
    if (load) next_state = addr_err ? S_ERR1 : S_DATA;
  end

  // Address-phase register and wait counter; the counter only reloads on an accept.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      word_q   <= '0;
      lanes_q  <= '0;
      write_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (load) begin
        wait_cnt <= WS_LOAD;
        word_q   <= haddr[IW+1:2];
        lanes_q  <= lane_enable(hsize, haddr[1:0]);
        write_q  <= hwrite;
      end else if ((state == S_DATA) && !done) begin
        wait_cnt <= wait_cnt - CW'(1);
      end
    end
  end

  ahb_slave_mem #(
    .WORDS(WORDS),
    .IW   (IW)
  ) u_mem (
    .hclk (hclk),
    .we   (mem_we),
    .be   (lanes_q),
    .addr (word_q),
    .wdata(hwdata),
    .rdata(mem_rdata)
  );

  assign hrdata = ((state == S_DATA) && done && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for the SRAM responder: one instance with zero wait states
// and one with two, sharing a master whose select steers to either.
module tb_ahb_lite_sram_slave;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_BUSY   = 2'd1;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [2:0] SZ_BYTE  = 3'd0;
  localparam logic [2:0] SZ_HALF  = 3'd1;
  localparam logic [2:0] SZ_WORD  = 3'd2;

  localparam logic [31:0] WR_ADDR [4] = '{32'h10, 32'h13, 32'h10, 32'h12};
  localparam logic [2:0]  WR_SIZE [4] = '{SZ_WORD, SZ_BYTE, SZ_HALF, SZ_HALF};
  localparam logic [31:0] WR_DATA [4] = '{32'hDEADBEEF, 32'hAA000000, 32'h00001234, 32'h56780000};
  localparam logic [31:0] RD_EXP  [4] = '{32'hDEADBEEF, 32'hAAADBEEF, 32'hAAAD1234, 32'h56781234};

  logic        hclk = 1'b0;
  logic        hreset;
  logic        sel2, hsel;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic        hsel0, hsel2, ro0, ro2, resp0, resp2, ro, resp;
  logic [31:0] rd0, rd2, rd;
  logic [33:0] obs, expv;

  int compared   = 0;
  int mismatched = 0;

  always #5 hclk = ~hclk;

  assign hsel0 = hsel & ~sel2;
  assign hsel2 = hsel & sel2;
  assign ro    = sel2 ? ro2 : ro0;
  assign resp  = sel2 ? resp2 : resp0;
  assign rd    = sel2 ? rd2 : rd0;

  ahb_lite_sram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(ro0),
    .hreadyout(ro0), .hresp(resp0), .hrdata(rd0)
  );

  ahb_lite_sram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024), .WAIT_STATES(2)) dut2 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(ro2),
    .hreadyout(ro2), .hresp(resp2), .hrdata(rd2)
  );

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_addr(input logic s, input logic [31:0] a, input logic [1:0] t,
                            input logic w, input logic [2:0] sz);
    hsel   = s;
    haddr  = a;
    htrans = t;
    hwrite = w;
    hsize  = sz;
  endtask

  task automatic drive_idle();
    drive_addr(1'b0, 32'h0, T_IDLE, 1'b0, SZ_WORD);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    if ({ro0, resp0, rd0} !== {1'b1, 1'b0, 32'h0}) begin
      mismatched++;
      $display("[TB] FAIL reset_ws0: got %b/%b/%h want 1/0/00000000", ro0, resp0, rd0);
    end
    compared++;
    if ({ro2, resp2, rd2} !== {1'b1, 1'b0, 32'h0}) begin
      mismatched++;
      $display("[TB] FAIL reset_ws2: got %b/%b/%h want 1/0/00000000", ro2, resp2, rd2);
    end
    compared++;
    hreset = 1'b0;
    step();
  endtask

  // Word write then sub-word merges, each followed directly by a read of word 0x10.
  task automatic test_write_read();
    sel2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_addr(1'b1, WR_ADDR[i], T_NONSEQ, 1'b1, WR_SIZE[i]);
      step();
      hwdata = WR_DATA[i];
      drive_addr(1'b1, 32'h10, T_NONSEQ, 1'b0, SZ_WORD);
      @(negedge hclk);
      if ({ro, resp, rd} !== {1'b1, 1'b0, 32'h0}) begin
        mismatched++;
        $display("[TB] FAIL write_phase_%0d: got %b/%b/%h want 1/0/00000000", i, ro, resp, rd);
      end
      compared++;
      step();
      drive_idle();
      hwdata = 32'h0;
      @(negedge hclk);
      if ({ro, resp, rd} !== {1'b1, 1'b0, RD_EXP[i]}) begin
        mismatched++;
        $display("[TB] FAIL read_back_%0d: got %b/%b/%h want 1/0/%h", i, ro, resp, rd, RD_EXP[i]);
      end
      compared++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    sel2 = 1'b0;
    drive_addr(1'b1, 32'h100, T_NONSEQ, 1'b1, SZ_WORD);
    step();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin hwdata = 32'h01234567; drive_addr(1'b1, 32'h104, T_NONSEQ, 1'b1, SZ_WORD); expv = {2'b10, 32'h0}; end
        1: begin hwdata = 32'h89ABCDEF; drive_addr(1'b1, 32'h100, T_NONSEQ, 1'b0, SZ_WORD); expv = {2'b10, 32'h0}; end
        2: begin hwdata = 32'h0; drive_addr(1'b1, 32'h104, T_NONSEQ, 1'b0, SZ_WORD); expv = {2'b10, 32'h01234567}; end
        default: begin drive_idle(); expv = {2'b10, 32'h89ABCDEF}; end
      endcase
      @(negedge hclk);
      obs = {ro, resp, rd};
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL b2b_cycle_%0d: got %h want %h", c, obs, expv);
      end
      compared++;
      step();
    end
  endtask

  task automatic test_errors();
    sel2 = 1'b0;
    // Misaligned half write, then a retried read issued during the second error cycle.
    drive_addr(1'b1, 32'h11, T_NONSEQ, 1'b1, SZ_HALF);
    step();
    hwdata = 32'hFFFFFFFF;
    drive_addr(1'b1, 32'h10, T_NONSEQ, 1'b0, SZ_WORD);
    @(negedge hclk);
    if ({ro, resp, rd} !== {1'b0, 1'b1, 32'h0}) begin
      mismatched++;
      $display("[TB] FAIL err1_half: got %b/%b/%h want 0/1/00000000", ro, resp, rd);
    end
    compared++;
    step();
    @(negedge hclk);
    if ({ro, resp, rd} !== {1'b1, 1'b1, 32'h0}) begin
      mismatched++;
      $display("[TB] FAIL err2_half: got %b/%b/%h want 1/1/00000000", ro, resp, rd);
    end
    compared++;
    step();
    drive_idle();
    hwdata = 32'h0;
    @(negedge hclk);
    if ({ro, resp, rd} !== {1'b1, 1'b0, 32'h56781234}) begin
      mismatched++;
      $display("[TB] FAIL err_retry_read: got %b/%b/%h want 1/0/56781234", ro, resp, rd);
    end
    compared++;
    step();
    for (int e = 0; e < 2; e++) begin
      if (e == 0) drive_addr(1'b1, 32'h400, T_NONSEQ, 1'b0, SZ_WORD);
      else        drive_addr(1'b1, 32'h0, T_NONSEQ, 1'b0, 3'd3);
      step();
      drive_idle();
      @(negedge hclk);
      if ({ro, resp, rd} !== {1'b0, 1'b1, 32'h0}) begin
        mismatched++;
        $display("[TB] FAIL err1_case_%0d: got %b/%b/%h want 0/1/00000000", e, ro, resp, rd);
      end
      compared++;
      step();
      @(negedge hclk);
      if ({ro, resp, rd} !== {1'b1, 1'b1, 32'h0}) begin
        mismatched++;
        $display("[TB] FAIL err2_case_%0d: got %b/%b/%h want 1/1/00000000", e, ro, resp, rd);
      end
      compared++;
      step();
    end
  endtask

  task automatic test_idle_busy_nosel();
    sel2 = 1'b0;
    hwdata = 32'hFFFFFFFF;
    for (int n = 0; n < 3; n++) begin
      case (n)
        0: drive_addr(1'b1, 32'h10, T_BUSY, 1'b1, SZ_WORD);
        1: drive_addr(1'b1, 32'h10, T_IDLE, 1'b1, SZ_WORD);
        default: drive_addr(1'b0, 32'h10, T_NONSEQ, 1'b1, SZ_WORD);
      endcase
      step();
      @(negedge hclk);
      if ({ro, resp, rd} !== {1'b1, 1'b0, 32'h0}) begin
        mismatched++;
        $display("[TB] FAIL no_access_%0d: got %b/%b/%h want 1/0/00000000", n, ro, resp, rd);
      end
      compared++;
    end
    drive_addr(1'b1, 32'h10, T_NONSEQ, 1'b0, SZ_WORD);
    step();
    drive_idle();
    hwdata = 32'h0;
    @(negedge hclk);
    if ({ro, resp, rd} !== {1'b1, 1'b0, 32'h56781234}) begin
      mismatched++;
      $display("[TB] FAIL no_access_mem: got %b/%b/%h want 1/0/56781234", ro, resp, rd);
    end
    compared++;
    step();
  endtask

  // Two writes then two reads, each next address held on the bus through the waits.
  task automatic test_wait_states();
    logic [31:0] ba [4];
    logic        bw [4];
    logic [31:0] bd [4];
    ba = '{32'h10, 32'h14, 32'h10, 32'h14};
    bw = '{1'b1, 1'b1, 1'b0, 1'b0};
    bd = '{32'hCAFEF00D, 32'h0BADC0DE, 32'hCAFEF00D, 32'h0BADC0DE};
    sel2 = 1'b1;
    drive_addr(1'b1, ba[0], T_NONSEQ, bw[0], SZ_WORD);
    step();
    for (int i = 0; i < 4; i++) begin
      hwdata = bw[i] ? bd[i] : 32'h0;
      if (i < 3) drive_addr(1'b1, ba[i+1], T_NONSEQ, bw[i+1], SZ_WORD);
      else       drive_idle();
      for (int k = 0; k < 3; k++) begin
        expv = {(k == 2), 1'b0, (!bw[i] && k == 2) ? bd[i] : 32'h0};
        @(negedge hclk);
        obs = {ro, resp, rd};
        if (obs !== expv) begin
          mismatched++;
          $display("[TB] FAIL ws2_beat%0d_cyc%0d: got %h want %h", i, k, obs, expv);
        end
        compared++;
        step();
      end
    end
  endtask

  task automatic test_ws_error();
    sel2 = 1'b1;
    drive_addr(1'b1, 32'h400, T_NONSEQ, 1'b0, SZ_WORD);
    step();
    drive_idle();
    @(negedge hclk);
    if ({ro, resp, rd} !== {1'b0, 1'b1, 32'h0}) begin
      mismatched++;
      $display("[TB] FAIL ws2_err1: got %b/%b/%h want 0/1/00000000", ro, resp, rd);
    end
    compared++;
    step();
    @(negedge hclk);
    if ({ro, resp, rd} !== {1'b1, 1'b1, 32'h0}) begin
      mismatched++;
      $display("[TB] FAIL ws2_err2: got %b/%b/%h want 1/1/00000000", ro, resp, rd);
    end
    compared++;
    step();
  endtask

  task automatic test_reset_mid_write();
    sel2 = 1'b1;
    drive_addr(1'b1, 32'h10, T_NONSEQ, 1'b1, SZ_WORD);
    step();
    hwdata = 32'h55555555;
    drive_idle();
    @(negedge hclk);
    if ({ro, resp, rd} !== {1'b0, 1'b0, 32'h0}) begin
      mismatched++;
      $display("[TB] FAIL mid_write_wait: got %b/%b/%h want 0/0/00000000", ro, resp, rd);
    end
    compared++;
    hreset = 1'b1;
    @(posedge hclk);
    @(negedge hclk);
    if ({ro, resp, rd} !== {1'b1, 1'b0, 32'h0}) begin
      mismatched++;
      $display("[TB] FAIL mid_run_reset: got %b/%b/%h want 1/0/00000000", ro, resp, rd);
    end
    compared++;
    hreset = 1'b0;
    step();
    drive_addr(1'b1, 32'h10, T_NONSEQ, 1'b0, SZ_WORD);
    step();
    drive_idle();
    hwdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      expv = {(k == 2), 1'b0, (k == 2) ? 32'hCAFEF00D : 32'h0};
      @(negedge hclk);
      obs = {ro, resp, rd};
      if (obs !== expv) begin
        mismatched++;
        $display("[TB] FAIL after_reset_read_cyc%0d: got %h want %h", k, obs, expv);
      end
      compared++;
      step();
    end
  endtask

  initial begin
    hreset = 1'b1;
    sel2   = 1'b0;
    hburst = 3'd0;
    hwdata = 32'h0;
    drive_idle();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_idle_busy_nosel();
    test_wait_states();
    test_ws_error();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
